// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: opcodes, datapath select encodings,
// FSM state enumeration and the decoded control bundle.
package bip_pkg;

  localparam int NBITS_D  = 16;
  localparam int NBITS_OP = 5;
  localparam int NBITS_A  = 11;

  localparam logic [NBITS_OP-1:0] OP_HLT  = 5'b00000;
  localparam logic [NBITS_OP-1:0] OP_STO  = 5'b00001;
  localparam logic [NBITS_OP-1:0] OP_LD   = 5'b00010;
  localparam logic [NBITS_OP-1:0] OP_LDI  = 5'b00011;
  localparam logic [NBITS_OP-1:0] OP_ADD  = 5'b00100;
  localparam logic [NBITS_OP-1:0] OP_ADDI = 5'b00101;
  localparam logic [NBITS_OP-1:0] OP_SUB  = 5'b00110;
  localparam logic [NBITS_OP-1:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SELA_MEM = 2'd0;
  localparam logic [1:0] SELA_IMM = 2'd1;
  localparam logic [1:0] SELA_ALU = 2'd2;

  localparam logic SELB_MEM = 1'b0;
  localparam logic SELB_IMM = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEMRD,
    ST_WB,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic       is_halt;
    logic       needs_mem;
    logic       wr_acc;
    logic       wr_ram;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
  } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: maps a BIP opcode to its control bundle.
// Unlisted opcodes decode to an all-zero bundle, which behaves as a NOP.
module bip_decoder
  import bip_pkg::*;
#(
  parameter int NBITS_OP = 5
) (
  input  logic [NBITS_OP-1:0] i_opcode,
  output ctrl_t               o_ctrl
);

  always_comb begin
    // NOTE: assigning the whole bundle first keeps every path driven, so no latch is inferred.
    o_ctrl = '0;
    case (i_opcode)
      OP_HLT: o_ctrl.is_halt = 1'b1;
      OP_STO: o_ctrl.wr_ram  = 1'b1;
      OP_LD: begin
        o_ctrl.needs_mem = 1'b1;
        o_ctrl.wr_acc    = 1'b1;
        o_ctrl.sel_a     = SELA_MEM;
      end
      OP_LDI: begin
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SELA_IMM;
      end
      OP_ADD, OP_SUB: begin
        o_ctrl.needs_mem = 1'b1;
        o_ctrl.wr_acc    = 1'b1;
        o_ctrl.sel_a     = SELA_ALU;
        o_ctrl.sel_b     = SELB_MEM;
        o_ctrl.op        = (i_opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
      end
      OP_ADDI, OP_SUBI: begin
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SELA_ALU;
        o_ctrl.sel_b  = SELB_IMM;
        o_ctrl.op     = (i_opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// Multi-cycle control unit for the BIP accumulator processor (PC, IR, FSM).
// Optional macro CU_INSN_COUNT_EN adds a 32-bit retired-instruction counter port.
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int NBITS_D  = 16,
  parameter int NBITS_OP = 5,
  parameter int NBITS_A  = 11
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NBITS_D-1:0] i_instr,
  output logic [NBITS_A-1:0] o_pc,
  output logic [NBITS_A-1:0] o_operand,
  output logic [1:0]         o_SelA,
  output logic               o_SelB,
  output logic               o_Op,
  output logic               o_WrAcc,
  output logic               o_RdRam,
  output logic               o_WrRam,
  output logic               o_halt
`ifdef CU_INSN_COUNT_EN
  ,
  output logic [31:0]        o_insn_count
`endif
);

  state_e              r_state;
  state_e              w_next_state;
  logic [NBITS_A-1:0]  r_pc;
  logic [NBITS_D-1:0]  r_ir;
  logic [NBITS_OP-1:0] w_opcode;
  ctrl_t               w_ctrl;

  // IR is only loaded at the end of DECODE, so decode the memory word directly there.
  assign w_opcode = (r_state == ST_DECODE) ? i_instr[NBITS_D-1 -: NBITS_OP]
                                           : r_ir[NBITS_D-1 -: NBITS_OP];

  bip_decoder #(.NBITS_OP(NBITS_OP)) u_decoder (
    .i_opcode (w_opcode),
    .o_ctrl   (w_ctrl)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      r_state <= w_next_state;
      if (r_state == ST_DECODE) r_ir <= i_instr;
      if (r_state == ST_WB)     r_pc <= r_pc + 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_SelA       = '0;
    o_SelB       = 1'b0;
    o_Op         = 1'b0;
    o_WrAcc      = 1'b0;
    o_RdRam      = 1'b0;
    o_WrRam      = 1'b0;
    case (r_state)
      ST_IDLE:  if (i_start) w_next_state = ST_FETCH;
      ST_FETCH: w_next_state = ST_DECODE;
      ST_DECODE: begin
        o_SelA = w_ctrl.sel_a;
        o_SelB = w_ctrl.sel_b;
        o_Op   = w_ctrl.op;
        if (w_ctrl.is_halt)        w_next_state = ST_HALT;
        else if (w_ctrl.needs_mem) w_next_state = ST_MEMRD;
        else                       w_next_state = ST_WB;
      end
      ST_MEMRD: begin
        o_SelA       = w_ctrl.sel_a;
        o_SelB       = w_ctrl.sel_b;
        o_Op         = w_ctrl.op;
        o_RdRam      = 1'b1;
        w_next_state = ST_WB;
      end
      ST_WB: begin
        o_SelA       = w_ctrl.sel_a;
        o_SelB       = w_ctrl.sel_b;
        o_Op         = w_ctrl.op;
        o_WrAcc      = w_ctrl.wr_acc;
        o_WrRam      = w_ctrl.wr_ram;
        w_next_state = ST_FETCH;
      end
      ST_HALT:  w_next_state = ST_HALT;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  assign o_pc      = r_pc;
  assign o_operand = r_ir[NBITS_A-1:0];
  assign o_halt    = (r_state == ST_HALT);

`ifdef CU_INSN_COUNT_EN
  logic [31:0] r_insn_count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)              r_insn_count <= '0;
    else if (r_state == ST_WB) r_insn_count <= r_insn_count + 32'd1;
  end

  assign o_insn_count = r_insn_count;
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench for bip_control_unit: directed scenarios plus random straight-line
// programs compared against an instruction-level interpreter of the BIP ISA.
module tb_bip_control_unit;

  localparam logic [4:0] HLT  = 5'b00000;
  localparam logic [4:0] STO  = 5'b00001;
  localparam logic [4:0] LD   = 5'b00010;
  localparam logic [4:0] LDI  = 5'b00011;
  localparam logic [4:0] ADD  = 5'b00100;
  localparam logic [4:0] ADDI = 5'b00101;
  localparam logic [4:0] SUB  = 5'b00110;
  localparam logic [4:0] SUBI = 5'b00111;

  logic        i_clk   = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_instr;
  logic [10:0] o_pc, o_operand;
  logic [1:0]  o_SelA;
  logic        o_SelB, o_Op, o_WrAcc, o_RdRam, o_WrRam, o_halt;
`ifdef CU_INSN_COUNT_EN
  logic [31:0] o_insn_count;
`endif

  bip_control_unit dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_instr   (i_instr),
    .o_pc      (o_pc),
    .o_operand (o_operand),
    .o_SelA    (o_SelA),
    .o_SelB    (o_SelB),
    .o_Op      (o_Op),
    .o_WrAcc   (o_WrAcc),
    .o_RdRam   (o_RdRam),
    .o_WrRam   (o_WrRam),
    .o_halt    (o_halt)
`ifdef CU_INSN_COUNT_EN
    ,
    .o_insn_count (o_insn_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_bad   = 0;

  // Program memory (1-cycle synchronous read) and a behavioural ACC/ALU/data-memory datapath.
  logic [15:0] pmem     [0:2047];
  logic [15:0] init_mem [0:2047];
  logic [15:0] dmem     [0:2047];
  logic [15:0] acc, rd_data;
  logic        dp_clear = 1'b0;
  logic [15:0] w_imm, w_opb, w_alu;

  always @(posedge i_clk) i_instr <= pmem[o_pc];

  assign w_imm = {5'b0, o_operand};
  assign w_opb = o_SelB ? w_imm : rd_data;
  assign w_alu = o_Op ? (acc - w_opb) : (acc + w_opb);

  always @(posedge i_clk) begin
    if (dp_clear) begin
      acc     <= '0;
      rd_data <= '0;
      for (int i = 0; i < 2048; i++) dmem[i] <= init_mem[i];
    end else begin
      if (o_RdRam) rd_data <= dmem[o_operand];
      if (o_WrRam) dmem[o_operand] <= acc;
      if (o_WrAcc) begin
        case (o_SelA)
          2'd0:    acc <= rd_data;
          2'd1:    acc <= w_imm;
          2'd2:    acc <= w_alu;
          default: acc <= 16'hdead;
        endcase
      end
    end
  end

  // Instruction-level reference results.
  logic [15:0] m_acc;
  logic [10:0] m_pc;
  int          m_cnt, m_cyc;
  logic [15:0] m_mem [0:2047];

  // Per-cycle trace, index = cycle number after the start edge (cycle 1 = first FETCH).
  logic [63:0] t_wracc, t_wrram, t_rdram, t_halt;
  logic [1:0]  t_sela [0:63];
  logic        t_selb [0:63];
  logic        t_op   [0:63];
  logic [10:0] t_pc   [0:63];
  logic [10:0] t_opnd [0:63];

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [10:0] a);
    return {op, a};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic fill_pmem(input logic [15:0] word);
    for (int i = 0; i < 2048; i++) pmem[i] = word;
  endtask

  task automatic clear_init_mem();
    for (int i = 0; i < 2048; i++) init_mem[i] = '0;
  endtask

  task automatic reset_dut();
    i_start  = 1'b0;
    i_reset  = 1'b0;
    dp_clear = 1'b1;
    tick();
    tick();
    dp_clear = 1'b0;
    i_reset  = 1'b1;
    tick();
  endtask

  task automatic start_run();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic run_trace(input int n);
    t_wracc = '0;
    t_wrram = '0;
    t_rdram = '0;
    t_halt  = '0;
    for (int c = 1; c <= n; c++) begin
      t_wracc[c] = o_WrAcc;
      t_wrram[c] = o_WrRam;
      t_rdram[c] = o_RdRam;
      t_halt[c]  = o_halt;
      t_sela[c]  = o_SelA;
      t_selb[c]  = o_SelB;
      t_op[c]    = o_Op;
      t_pc[c]    = o_pc;
      t_opnd[c]  = o_operand;
      tick();
    end
  endtask

  task automatic model_run();
    logic [15:0] ins;
    logic [10:0] a;
    logic [4:0]  op;
    int          steps;
    m_acc = '0;
    m_pc  = '0;
    m_cnt = 0;
    m_cyc = 0;
    steps = 0;
    for (int i = 0; i < 2048; i++) m_mem[i] = init_mem[i];
    ins = pmem[m_pc];
    while (ins[15:11] != HLT && steps < 4096) begin
      op = ins[15:11];
      a  = ins[10:0];
      case (op)
        STO:  m_mem[a] = m_acc;
        LD:   m_acc = m_mem[a];
        LDI:  m_acc = {5'b0, a};
        ADD:  m_acc = m_acc + m_mem[a];
        ADDI: m_acc = m_acc + {5'b0, a};
        SUB:  m_acc = m_acc - m_mem[a];
        SUBI: m_acc = m_acc - {5'b0, a};
        default: ;
      endcase
      m_cyc += (op == LD || op == ADD || op == SUB) ? 4 : 3;
      m_cnt++;
      m_pc = m_pc + 11'd1;
      steps++;
      ins = pmem[m_pc];
    end
    m_cyc += 2;
  endtask

  task automatic test_reset();
    logic [29:0] outs;
    fill_pmem(mk(LDI, 11'd77));
    clear_init_mem();
    reset_dut();
    start_run();
    tick();
    i_reset = 1'b0;
    #2;
    outs = {o_pc, o_operand, o_SelA, o_SelB, o_Op, o_WrAcc, o_RdRam, o_WrRam, o_halt};
    n_total++;
    if (outs !== 30'd0) begin
      n_bad++;
      $display("FAIL reset_async: outputs=%h expected 0", outs);
    end
    tick();
    outs = {o_pc, o_operand, o_SelA, o_SelB, o_Op, o_WrAcc, o_RdRam, o_WrRam, o_halt};
    n_total++;
    if (outs !== 30'd0) begin
      n_bad++;
      $display("FAIL reset_held: outputs=%h expected 0", outs);
    end
`ifdef CU_INSN_COUNT_EN
    n_total++;
    if (o_insn_count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_count: got %0d expected 0", o_insn_count);
    end
`endif
    i_reset = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    outs = {o_pc, o_operand, o_SelA, o_SelB, o_Op, o_WrAcc, o_RdRam, o_WrRam, o_halt};
    n_total++;
    if (outs !== 30'd0) begin
      n_bad++;
      $display("FAIL idle_without_start: outputs=%h expected 0", outs);
    end
  endtask

  task automatic test_example_program();
    fill_pmem(mk(HLT, 11'd0));
    clear_init_mem();
    pmem[0] = mk(LDI, 11'd5);
    pmem[1] = mk(ADDI, 11'd3);
    pmem[2] = mk(STO, 11'd10);
    pmem[3] = mk(HLT, 11'd0);
    reset_dut();
    start_run();
    run_trace(14);
    n_total++;
    if (t_wracc !== 64'h48) begin
      n_bad++;
      $display("FAIL example_wracc_cycles: got %h expected %h", t_wracc, 64'h48);
    end
    n_total++;
    if (t_wrram !== 64'h200 || t_opnd[9] !== 11'd10) begin
      n_bad++;
      $display("FAIL example_wrram: mask=%h operand=%0d expected mask=200 operand=10", t_wrram, t_opnd[9]);
    end
    n_total++;
    if (t_rdram !== 64'h0) begin
      n_bad++;
      $display("FAIL example_rdram: got %h expected 0", t_rdram);
    end
    n_total++;
    if (t_halt !== 64'h7000) begin
      n_bad++;
      $display("FAIL example_halt_cycles: got %h expected 7000", t_halt);
    end
    n_total++;
    if (acc !== 16'd8 || dmem[10] !== 16'd8) begin
      n_bad++;
      $display("FAIL example_data: acc=%0d mem10=%0d expected 8 and 8", acc, dmem[10]);
    end
    i_start = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    i_start = 1'b0;
    n_total++;
    if (o_pc !== 11'd3 || o_halt !== 1'b1) begin
      n_bad++;
      $display("FAIL halt_sticky: pc=%0d halt=%b expected pc=3 halt=1", o_pc, o_halt);
    end
`ifdef CU_INSN_COUNT_EN
    n_total++;
    if (o_insn_count !== 32'd3) begin
      n_bad++;
      $display("FAIL example_count: got %0d expected 3", o_insn_count);
    end
`endif
  endtask

  task automatic test_ld();
    logic [15:0] val;
    val = 16'($urandom) | 16'h1;
    fill_pmem(mk(HLT, 11'd0));
    clear_init_mem();
    init_mem[7] = val;
    pmem[0] = mk(LD, 11'd7);
    reset_dut();
    start_run();
    run_trace(8);
    n_total++;
    if (t_rdram !== 64'h8 || t_wracc !== 64'h10) begin
      n_bad++;
      $display("FAIL ld_strobes: rdram=%h wracc=%h expected 8 and 10", t_rdram, t_wracc);
    end
    n_total++;
    if (t_sela[4] !== 2'd0 || t_pc[5] !== 11'd1 || t_halt !== 64'h180) begin
      n_bad++;
      $display("FAIL ld_timing: sela=%0d next_pc=%0d halt=%h expected 0 1 180", t_sela[4], t_pc[5], t_halt);
    end
    n_total++;
    if (acc !== val) begin
      n_bad++;
      $display("FAIL ld_value: acc=%h expected %h", acc, val);
    end
  endtask

  task automatic test_sub();
    logic [15:0] val;
    val = 16'($urandom);
    fill_pmem(mk(HLT, 11'd0));
    clear_init_mem();
    init_mem[2] = val;
    pmem[0] = mk(LDI, 11'd100);
    pmem[1] = mk(SUB, 11'd2);
    reset_dut();
    start_run();
    run_trace(12);
    n_total++;
    if (t_wracc !== 64'h88 || t_rdram !== 64'h40 || t_halt !== 64'h1c00) begin
      n_bad++;
      $display("FAIL sub_strobes: wracc=%h rdram=%h halt=%h expected 88 40 1c00", t_wracc, t_rdram, t_halt);
    end
    n_total++;
    if (t_sela[4] !== 2'd0 || t_sela[5] !== 2'd2 || t_sela[6] !== 2'd2 || t_sela[7] !== 2'd2) begin
      n_bad++;
      $display("FAIL sub_sela_hold: fetch=%0d dec=%0d mem=%0d wb=%0d expected 0 2 2 2", t_sela[4], t_sela[5], t_sela[6], t_sela[7]);
    end
    n_total++;
    if (t_selb[7] !== 1'b0 || t_op[7] !== 1'b1) begin
      n_bad++;
      $display("FAIL sub_wb_selects: selb=%b op=%b expected 0 1", t_selb[7], t_op[7]);
    end
    n_total++;
    if (acc !== 16'(16'd100 - val)) begin
      n_bad++;
      $display("FAIL sub_value: acc=%h expected %h", acc, 16'(16'd100 - val));
    end
  endtask

  task automatic test_nop_wrap();
    int n;
    int viol;
    for (int i = 0; i < 2048; i++) pmem[i] = {5'($urandom_range(8, 31)), 11'($urandom)};
    clear_init_mem();
    reset_dut();
    start_run();
    n = 0;
    viol = 0;
    while (o_pc !== 11'd2047 && n < 7000) begin
      if ({o_SelA, o_SelB, o_Op, o_WrAcc, o_RdRam, o_WrRam, o_halt} !== 8'd0) viol++;
      tick();
      n++;
    end
    n_total++;
    if (n !== 6141) begin
      n_bad++;
      $display("FAIL nop_reach_2047: cycles=%0d expected 6141", n);
    end
    n_total++;
    if (viol !== 0) begin
      n_bad++;
      $display("FAIL nop_no_strobes: active cycles=%0d expected 0", viol);
    end
    tick();
    tick();
    n_total++;
    if (o_pc !== 11'd2047) begin
      n_bad++;
      $display("FAIL nop_pc_before_wb: pc=%0d expected 2047", o_pc);
    end
    tick();
    n_total++;
    if (o_pc !== 11'd0 || o_halt !== 1'b0) begin
      n_bad++;
      $display("FAIL pc_wrap: pc=%0d halt=%b expected 0 0", o_pc, o_halt);
    end
  endtask

  task automatic test_reset_mid_instruction();
    logic [29:0] outs;
    fill_pmem(mk(HLT, 11'd0));
    clear_init_mem();
    init_mem[4] = 16'($urandom) | 16'h1;
    pmem[0] = mk(LDI, 11'd9);
    pmem[1] = mk(ADD, 11'd4);
    reset_dut();
    start_run();
    for (int c = 0; c < 5; c++) tick();
    n_total++;
    if (o_RdRam !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reach_memrd: rdram=%b expected 1", o_RdRam);
    end
    #2;
    i_reset = 1'b0;
    #1;
    tick();
    outs = {o_pc, o_operand, o_SelA, o_SelB, o_Op, o_WrAcc, o_RdRam, o_WrRam, o_halt};
    n_total++;
    if (outs !== 30'd0 || acc !== 16'd9) begin
      n_bad++;
      $display("FAIL mid_reset: outputs=%h acc=%0d expected 0 and 9", outs, acc);
    end
    i_reset = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    outs = {o_pc, o_operand, o_SelA, o_SelB, o_Op, o_WrAcc, o_RdRam, o_WrRam, o_halt};
    n_total++;
    if (outs !== 30'd0 || acc !== 16'd9) begin
      n_bad++;
      $display("FAIL mid_reset_idle: outputs=%h acc=%0d expected 0 and 9", outs, acc);
    end
  endtask

  task automatic test_random_programs();
    int len, n, viol, nmis;
    logic [4:0] op;
    for (int p = 0; p < 12; p++) begin
      fill_pmem(mk(HLT, 11'd0));
      for (int i = 0; i < 2048; i++) init_mem[i] = 16'($urandom);
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        op = 5'($urandom_range(1, 31));
        if ($urandom_range(0, 3) != 0) op = 5'($urandom_range(1, 7));
        pmem[i] = mk(op, ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 15)) : 11'($urandom));
      end
      model_run();
      reset_dut();
      start_run();
      n = 0;
      viol = 0;
      while (o_halt !== 1'b1 && n < 200) begin
        if ((o_WrAcc && o_WrRam) || (o_RdRam && (o_WrAcc || o_WrRam))) viol++;
        tick();
        n++;
      end
      n_total++;
      if (n !== m_cyc || viol !== 0) begin
        n_bad++;
        $display("FAIL rand%0d_cycles: cycles=%0d overlaps=%0d expected %0d and 0", p, n, viol, m_cyc);
      end
      n_total++;
      if (acc !== m_acc || o_pc !== m_pc) begin
        n_bad++;
        $display("FAIL rand%0d_state: acc=%h pc=%0d expected %h %0d", p, acc, o_pc, m_acc, m_pc);
      end
      nmis = 0;
      for (int i = 0; i < 2048; i++) if (dmem[i] !== m_mem[i]) nmis++;
      n_total++;
      if (nmis !== 0) begin
        n_bad++;
        $display("FAIL rand%0d_dmem: differing words=%0d expected 0", p, nmis);
      end
`ifdef CU_INSN_COUNT_EN
      n_total++;
      if (o_insn_count !== 32'(m_cnt)) begin
        n_bad++;
        $display("FAIL rand%0d_count: got %0d expected %0d", p, o_insn_count, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_example_program();
    test_ld();
    test_sub();
    test_reset_mid_instruction();
    test_random_programs();
    test_nop_wrap();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
